// File: rtl/spi_shift_ctrl.sv
// spi_shift_ctrl: SPI mode-0 master transaction controller and shift engine.
// Accepts a word over valid/ready, frames it with cs_n, drives the clock
// divider (start/n_pulses), shifts MOSI on spi_clk falls, samples MISO on
// rises and returns the received word with a one-cycle rx_valid strobe.
// A watchdog aborts the transfer if the divider stops producing edges.
module spi_shift_ctrl #(
  parameter int SPI_MAXLEN     = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int LW = $clog2(SPI_MAXLEN) + 1,
  localparam int WW = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SPI_MAXLEN-1:0] tx_data,
  input  logic [LW-1:0]         tx_len,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic                  spi_clk,
  output logic                  start,
  output logic [LW-1:0]         n_pulses,
  input  logic                  miso,
  output logic                  mosi,
  output logic                  cs_n,
  output logic [SPI_MAXLEN-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  sclk_q;
  logic [SPI_MAXLEN-1:0] tx_q, tx_d;
  logic [SPI_MAXLEN-1:0] rx_q, rx_d;
  logic [SPI_MAXLEN-1:0] rx_data_q, rx_data_d;
  logic [LW-1:0]         len_q, len_d;
  logic [LW-1:0]         bcnt_q, bcnt_d;
  logic [WW-1:0]         wdog_q, wdog_d;
  logic                  mosi_q, mosi_d;
  logic                  err_q, err_d;

  logic                  rise, fall;
  logic [LW-1:0]         len_clamp;
  logic                  first_bit;
  logic                  next_bit;
  logic [SPI_MAXLEN-1:0] len_mask;

  // spi_clk is already synchronous to clk, so one register is enough for edges
  assign rise = spi_clk & ~sclk_q;
  assign fall = ~spi_clk & sclk_q;

  // Over-long requests are clamped to the widest transfer the engine supports
  assign len_clamp = (tx_len > LW'(SPI_MAXLEN)) ? LW'(SPI_MAXLEN) : tx_len;

  // Bit len-1 of the request goes out during SETUP; a zero length selects nothing
  assign first_bit = |(tx_data & (SPI_MAXLEN'(1) << (len_clamp - LW'(1))));

  // After k rises bcnt = len-k, so the next bit to present is index bcnt-1
  assign next_bit = |(tx_q & (SPI_MAXLEN'(1) << (bcnt_q - LW'(1))));

  // Keeps only the low len bits of the received word
  assign len_mask = ~({SPI_MAXLEN{1'b1}} << len_q);

  assign n_pulses = len_q;
  assign mosi     = mosi_q;
  assign rx_data  = rx_data_q;
  assign err      = err_q;

  // State register and datapath registers; reset aborts any transfer at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sclk_q    <= 1'b0;
      tx_q      <= '0;
      rx_q      <= '0;
      rx_data_q <= '0;
      len_q     <= '0;
      bcnt_q    <= '0;
      wdog_q    <= '0;
      mosi_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sclk_q    <= spi_clk;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rx_data_q <= rx_data_d;
      len_q     <= len_d;
      bcnt_q    <= bcnt_d;
      wdog_q    <= wdog_d;
      mosi_q    <= mosi_d;
      err_q     <= err_d;
    end
  end

  // Next-state, datapath updates and state-decoded outputs
  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rx_data_d = rx_data_q;
    len_d     = len_q;
    bcnt_d    = bcnt_q;
    wdog_d    = '0;
    mosi_d    = mosi_q;
    err_d     = 1'b0;

    tx_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    start     = (state_q == S_SHIFT);
    cs_n      = !((state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD));
    rx_valid  = (state_q == S_DONE);

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          tx_d   = tx_data;
          rx_d   = '0;
          len_d  = len_clamp;
          bcnt_d = len_clamp;
          mosi_d = first_bit;
          if (len_clamp == '0) begin
            // Empty transfer: no framing, report an all-zero word immediately
            rx_data_d = '0;
            state_d   = S_DONE;
          end else begin
            state_d = S_SETUP;
          end
        end
      end

      S_SETUP: begin
        state_d = S_SHIFT;
      end

      S_SHIFT: begin
        if (!rise && !fall && (wdog_q != WW'(TIMEOUT_CYCLES))) begin
          wdog_d = wdog_q + WW'(1);
        end
        if (rise) begin
          rx_d   = {rx_q[SPI_MAXLEN-2:0], miso};
          bcnt_d = (bcnt_q != '0) ? (bcnt_q - LW'(1)) : '0;
        end
        if (fall && (bcnt_q != '0)) begin
          mosi_d = next_bit;
        end
        if ((bcnt_q == '0) && !spi_clk) begin
          state_d = S_HOLD;
        end else if (!rise && !fall && (wdog_q >= WW'(TIMEOUT_CYCLES - 1))) begin
          // Divider stalled: abandon the transfer, rx_data keeps its old value
          state_d = S_IDLE;
          err_d   = 1'b1;
          mosi_d  = 1'b0;
          wdog_d  = '0;
        end
      end

      S_HOLD: begin
        rx_data_d = rx_q & len_mask;
        mosi_d    = 1'b0;
        state_d   = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_shift_ctrl.sv
// tb_spi_shift_ctrl: randomized bench for spi_shift_ctrl with a clock-divider
// and mode-0 slave model; expectations come from word-level arithmetic.
module tb_spi_shift_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] tx_data;
  logic [4:0]  tx_len;
  logic        tx_valid;
  logic        tx_ready;
  logic        spi_clk = 1'b0;
  logic        start;
  logic [4:0]  n_pulses;
  logic        miso = 1'b0;
  logic        mosi;
  logic        cs_n;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        busy;
  logic        err;

  spi_shift_ctrl #(.SPI_MAXLEN(16), .TIMEOUT_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_len(tx_len), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .spi_clk(spi_clk), .start(start), .n_pulses(n_pulses),
    .miso(miso), .mosi(mosi), .cs_n(cs_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // divider / slave model state
  int          half = 2;
  bit          stall = 1'b0;
  bit          loopback = 1'b0;
  int          exp_len = 0;
  logic [15:0] slave_word = '0;
  int          div_cnt = 0;
  int          pulses = 0;
  int          sidx = -1;
  int          rise_cnt = 0;
  int          cs_bad = 0;
  logic        mosi_log[$];
  logic [15:0] slave_sh;

  // per-transfer observations
  int          obs_end, rxv_cnt, err_cnt, start_cnt, cs_low_cnt, cs_high_mid, np_changes;
  bit          timed_out;
  logic        t1_cs, t1_ready, t1_busy, t1_rxv, t2_start;
  logic        cs_at_end, start_at_end, ready_at_end, ready_post, cs_post;
  logic [15:0] obs_rx, rx_at_err, obs_mosi;
  logic [4:0]  np_first;

  function automatic logic [15:0] mask16(input int n);
    return 16'((32'h1 << n) - 1);
  endfunction

  // Clock divider: n_pulses pulses of spi_clk while start is high; slave
  // presents MSB first and advances its bit on each falling spi_clk.
  always @(negedge clk) begin
    if (!start) begin
      spi_clk = 1'b0;
      div_cnt = 0;
      pulses  = 0;
      sidx    = exp_len - 1;
    end else if (!stall) begin
      div_cnt++;
      if (div_cnt >= half) begin
        div_cnt = 0;
        if (spi_clk) begin
          spi_clk = 1'b0;
          sidx--;
        end else if (pulses < int'(n_pulses)) begin
          spi_clk = 1'b1;
          pulses++;
          rise_cnt++;
          mosi_log.push_back(mosi);
          if (cs_n) cs_bad++;
        end
      end
    end
    slave_sh = slave_word >> sidx;
    miso = loopback ? mosi : ((sidx >= 0) ? slave_sh[0] : 1'b0);
  end

  // Runs one request and records what the DUT did; comparisons live in the tests.
  task automatic run_xfer(input int len_in, input logic [15:0] data, input logic [15:0] sw,
                          input bit loop_en, input bit keep_valid);
    int k;
    exp_len = (len_in > 16) ? 16 : len_in;
    slave_word = sw;
    loopback = loop_en;
    mosi_log.delete();
    rise_cnt = 0; cs_bad = 0;
    obs_end = 0; rxv_cnt = 0; err_cnt = 0; start_cnt = 0; cs_low_cnt = 0;
    cs_high_mid = 0; np_changes = 0; timed_out = 1'b0;
    t1_cs = 1'b1; t1_ready = 1'b1; t1_busy = 1'b0; t1_rxv = 1'b0; t2_start = 1'b0;
    cs_at_end = 1'b0; start_at_end = 1'b1; ready_at_end = 1'b0; ready_post = 1'b0; cs_post = 1'b1;
    obs_rx = '0; rx_at_err = '0; np_first = '0;
    tx_data = data; tx_len = 5'(len_in); tx_valid = 1'b1;
    k = 0;
    while (!tx_ready && k < 50) begin @(negedge clk); k++; end
    if (!tx_ready) timed_out = 1'b1;
    @(negedge clk);
    if (!keep_valid) begin
      tx_valid = 1'b0; tx_data = 16'($urandom); tx_len = 5'($urandom);
    end
    for (int cyc = 1; cyc <= 400; cyc++) begin
      if (cyc == 1) begin
        t1_cs = cs_n; t1_ready = tx_ready; t1_busy = busy; t1_rxv = rx_valid; np_first = n_pulses;
      end
      if (cyc == 2) t2_start = start;
      if (start) start_cnt++;
      if (!cs_n) begin
        cs_low_cnt++;
        if (n_pulses !== np_first) np_changes++;
      end
      if (rx_valid) begin
        rxv_cnt++;
        if (obs_end == 0) begin obs_end = cyc; obs_rx = rx_data; cs_at_end = cs_n; end
      end
      if (err) begin
        err_cnt++;
        if (obs_end == 0) begin
          obs_end = cyc; rx_at_err = rx_data; cs_at_end = cs_n;
          start_at_end = start; ready_at_end = tx_ready;
        end
      end
      if (obs_end == 0 && cs_n) cs_high_mid++;
      if (obs_end != 0 && cyc == obs_end + 1) ready_post = tx_ready;
      if (obs_end != 0 && cyc == obs_end + 2) begin cs_post = cs_n; break; end
      @(negedge clk);
    end
    if (obs_end == 0) timed_out = 1'b1;
    obs_mosi = '0;
    foreach (mosi_log[i]) obs_mosi = {obs_mosi[14:0], mosi_log[i]};
    $display("xfer len=%0d data=%h slave=%h loop=%0d -> rx=%h rises=%0d rxv=%0d err=%0d",
             len_in, data, sw, loop_en, obs_rx, rise_cnt, rxv_cnt, err_cnt);
  endtask

  task automatic test_reset();
    rst = 1'b1; tx_valid = 1'b0; tx_data = '0; tx_len = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (cs_n !== 1'b1) begin n_bad++; $display("FAIL reset_cs_n: got %b expected 1", cs_n); end
    n_cmp++; if (mosi !== 1'b0) begin n_bad++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
    n_cmp++; if (start !== 1'b0) begin n_bad++; $display("FAIL reset_start: got %b expected 0", start); end
    n_cmp++; if (n_pulses !== 5'd0) begin n_bad++; $display("FAIL reset_n_pulses: got %0d expected 0", n_pulses); end
    n_cmp++; if (rx_data !== 16'h0) begin n_bad++; $display("FAIL reset_rx_data: got %h expected 0000", rx_data); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", err); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_tx_ready: got %b expected 1", tx_ready); end
    $display("reset check done");
  endtask

  task automatic test_basic_a5();
    half = 2;
    run_xfer(8, 16'h00A5, 16'h003C, 1'b0, 1'b0);
    n_cmp++; if (timed_out) begin n_bad++; $display("FAIL a5_complete: got timeout expected rx_valid"); end
    n_cmp++; if (obs_mosi !== 16'h00A5) begin n_bad++; $display("FAIL a5_mosi_bits: got %h expected 00a5", obs_mosi); end
    n_cmp++; if (obs_rx !== 16'h003C) begin n_bad++; $display("FAIL a5_rx_data: got %h expected 003c", obs_rx); end
    n_cmp++; if (rxv_cnt != 1) begin n_bad++; $display("FAIL a5_rx_valid_pulses: got %0d expected 1", rxv_cnt); end
    n_cmp++; if (rise_cnt != 8) begin n_bad++; $display("FAIL a5_rises: got %0d expected 8", rise_cnt); end
    n_cmp++; if (cs_bad != 0 || cs_high_mid != 0) begin n_bad++; $display("FAIL a5_cs_low: got %0d high cycles expected 0", cs_bad + cs_high_mid); end
    n_cmp++; if (t1_cs !== 1'b0 || t1_ready !== 1'b0 || t1_busy !== 1'b1) begin n_bad++; $display("FAIL a5_setup: got cs_n=%b ready=%b busy=%b expected 0 0 1", t1_cs, t1_ready, t1_busy); end
    n_cmp++; if (t2_start !== 1'b1) begin n_bad++; $display("FAIL a5_start_t2: got %b expected 1", t2_start); end
    n_cmp++; if (np_first !== 5'd8 || np_changes != 0) begin n_bad++; $display("FAIL a5_n_pulses: got %0d (%0d changes) expected 8 stable", np_first, np_changes); end
    n_cmp++; if (cs_at_end !== 1'b1) begin n_bad++; $display("FAIL a5_cs_at_rx_valid: got %b expected 1", cs_at_end); end
    n_cmp++; if (ready_post !== 1'b1) begin n_bad++; $display("FAIL a5_ready_after: got %b expected 1", ready_post); end
  endtask

  task automatic test_loopback_clamp();
    logic [15:0] d;
    half = 1;
    run_xfer(16, 16'hFFFF, 16'h0000, 1'b1, 1'b0);
    n_cmp++; if (obs_rx !== 16'hFFFF || timed_out) begin n_bad++; $display("FAIL loop16_rx: got %h expected ffff", obs_rx); end
    d = 16'($urandom);
    half = 3;
    run_xfer(20, d, 16'h0000, 1'b1, 1'b0);
    n_cmp++; if (np_first !== 5'd16) begin n_bad++; $display("FAIL clamp_n_pulses: got %0d expected 16", np_first); end
    n_cmp++; if (obs_rx !== d || rise_cnt != 16) begin n_bad++; $display("FAIL clamp_rx: got %h/%0d rises expected %h/16", obs_rx, rise_cnt, d); end
  endtask

  task automatic test_zero_len();
    half = 2;
    run_xfer(0, 16'hBEEF, 16'hFFFF, 1'b0, 1'b0);
    n_cmp++; if (obs_end != 1 || t1_rxv !== 1'b1) begin n_bad++; $display("FAIL zero_rx_valid_cycle: got %0d expected 1", obs_end); end
    n_cmp++; if (obs_rx !== 16'h0000) begin n_bad++; $display("FAIL zero_rx_data: got %h expected 0000", obs_rx); end
    n_cmp++; if (cs_low_cnt != 0 || start_cnt != 0) begin n_bad++; $display("FAIL zero_no_frame: got cs_low=%0d start=%0d expected 0 0", cs_low_cnt, start_cnt); end
    n_cmp++; if (rxv_cnt != 1) begin n_bad++; $display("FAIL zero_rx_valid_pulses: got %0d expected 1", rxv_cnt); end
  endtask

  task automatic test_timeout();
    logic [15:0] prev_rx;
    prev_rx = rx_data;
    stall = 1'b1;
    run_xfer(8, 16'h1234, 16'h5678, 1'b0, 1'b0);
    stall = 1'b0;
    n_cmp++; if (err_cnt != 1) begin n_bad++; $display("FAIL timeout_err_pulses: got %0d expected 1", err_cnt); end
    n_cmp++; if (start_cnt != 32) begin n_bad++; $display("FAIL timeout_cycles: got %0d expected 32", start_cnt); end
    n_cmp++; if (rxv_cnt != 0) begin n_bad++; $display("FAIL timeout_no_rx_valid: got %0d expected 0", rxv_cnt); end
    n_cmp++; if (cs_at_end !== 1'b1 || start_at_end !== 1'b0) begin n_bad++; $display("FAIL timeout_release: got cs_n=%b start=%b expected 1 0", cs_at_end, start_at_end); end
    n_cmp++; if (ready_at_end !== 1'b1) begin n_bad++; $display("FAIL timeout_tx_ready: got %b expected 1", ready_at_end); end
    n_cmp++; if (rx_at_err !== prev_rx) begin n_bad++; $display("FAIL timeout_rx_kept: got %h expected %h", rx_at_err, prev_rx); end
  endtask

  task automatic test_reset_mid();
    int k;
    logic [15:0] sw;
    exp_len = 16; slave_word = 16'h1234; loopback = 1'b0; half = 2; rise_cnt = 0;
    tx_data = 16'hFFFF; tx_len = 5'd16; tx_valid = 1'b1;
    k = 0;
    while (!tx_ready && k < 50) begin @(negedge clk); k++; end
    @(negedge clk);
    tx_valid = 1'b0;
    k = 0;
    while (rise_cnt < 3 && k < 200) begin @(negedge clk); k++; end
    n_cmp++; if (rise_cnt < 3) begin n_bad++; $display("FAIL midrst_reach_rise3: got %0d expected 3", rise_cnt); end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (cs_n !== 1'b1 || start !== 1'b0 || busy !== 1'b0 || tx_ready !== 1'b1) begin n_bad++; $display("FAIL midrst_ctrl: got cs_n=%b start=%b busy=%b ready=%b expected 1 0 0 1", cs_n, start, busy, tx_ready); end
    n_cmp++; if (mosi !== 1'b0 || n_pulses !== 5'd0) begin n_bad++; $display("FAIL midrst_data: got mosi=%b n_pulses=%0d expected 0 0", mosi, n_pulses); end
    n_cmp++; if (rx_data !== 16'h0 || rx_valid !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL midrst_rx: got rx=%h rxv=%b err=%b expected 0000 0 0", rx_data, rx_valid, err); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sw = 16'($urandom);
    run_xfer(4, 16'h0009, sw, 1'b0, 1'b0);
    n_cmp++; if (obs_mosi !== 16'h0009 || rise_cnt != 4) begin n_bad++; $display("FAIL post_rst_mosi: got %h/%0d expected 0009/4", obs_mosi, rise_cnt); end
    n_cmp++; if (obs_rx !== (sw & 16'h000F) || rxv_cnt != 1) begin n_bad++; $display("FAIL post_rst_rx: got %h expected %h", obs_rx, sw & 16'h000F); end
  endtask

  task automatic test_back_to_back();
    int k;
    logic [15:0] d, sw;
    d = 16'($urandom); sw = 16'($urandom); half = 1;
    run_xfer(8, d, sw, 1'b0, 1'b1);
    n_cmp++; if (obs_rx !== (sw & 16'h00FF)) begin n_bad++; $display("FAIL b2b_first_rx: got %h expected %h", obs_rx, sw & 16'h00FF); end
    n_cmp++; if (ready_post !== 1'b1 || cs_post !== 1'b0) begin n_bad++; $display("FAIL b2b_reaccept: got ready=%b cs_n=%b expected 1 0", ready_post, cs_post); end
    tx_valid = 1'b0;
    k = 0;
    while (!rx_valid && k < 300) begin @(negedge clk); k++; end
    n_cmp++; if (rx_valid !== 1'b1 || rx_data !== (sw & 16'h00FF)) begin n_bad++; $display("FAIL b2b_second_rx: got %h (valid %b) expected %h", rx_data, rx_valid, sw & 16'h00FF); end
    $display("xfer back-to-back second rx=%h", rx_data);
    @(negedge clk);
  endtask

  task automatic test_random();
    int len;
    bit lp;
    logic [15:0] d, sw, exp_rx, exp_mosi;
    int el;
    for (int it = 0; it < 24; it++) begin
      len = $urandom_range(0, 20);
      d = 16'($urandom); sw = 16'($urandom);
      lp = 1'($urandom_range(0, 1));
      half = $urandom_range(1, 3);
      el = (len > 16) ? 16 : len;
      exp_mosi = d & mask16(el);
      exp_rx = lp ? exp_mosi : (sw & mask16(el));
      run_xfer(len, d, sw, lp, 1'b0);
      n_cmp++; if (timed_out || rxv_cnt != 1) begin n_bad++; $display("FAIL rnd%0d_rx_valid: got %0d pulses expected 1", it, rxv_cnt); end
      n_cmp++; if (obs_rx !== exp_rx) begin n_bad++; $display("FAIL rnd%0d_rx_data: got %h expected %h", it, obs_rx, exp_rx); end
      n_cmp++; if (obs_mosi !== exp_mosi || rise_cnt != el) begin n_bad++; $display("FAIL rnd%0d_mosi: got %h/%0d expected %h/%0d", it, obs_mosi, rise_cnt, exp_mosi, el); end
      n_cmp++; if (np_first !== 5'(el)) begin n_bad++; $display("FAIL rnd%0d_n_pulses: got %0d expected %0d", it, np_first, el); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_a5();
    test_loopback_clamp();
    test_zero_len();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got no finish expected finish");
    $fatal(1, "time limit");
  end

endmodule
